cgra_prog_ctrl: RTL and testbench

Configuration sequencer for the CGRA tile program chain. Accepts configuration words from a host over a valid/ready stream and serializes them LSB-first onto the daisy-chained tile program input. It drives the chain's program_mode and reset, and tracks which tile window is currently being filled. One instance sits at the head of the tile chain.

---
 rtl/cgra_prog_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cgra_prog_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_prog_ctrl.sv
// cgra_prog_ctrl
//   Configuration sequencer at the head of the CGRA tile program chain.
//   It takes host words over a valid/ready stream and shifts them LSB-first
//   onto the daisy-chained tile program input. It also drives the chain's
//   program_mode and reset, and tracks which tile window is being filled.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a programming pass (sampled in IDLE only)
//   abort      cancel the pass, back to IDLE next cycle
//   in_data    configuration word, bit 0 shifted first
//   in_valid   in_data valid
//   in_ready   word accepted this cycle (depends on state, bits_left, abort)
//   ser_data   serial bit to the chain data input
//   prog_mode  chain program_mode, high only while a valid bit is on ser_data
//   chain_rst  one-cycle pulse clearing the tiles' bit counters
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the final bit
//   aborted    one-cycle pulse when abort takes effect
//   bit_cnt    bits shifted in this pass
//   tile_idx   tile whose window receives the current bit
//
// state  | meaning
// IDLE   | waiting for start
// CLR    | chain_rst pulse, pass counters cleared
// FETCH  | waiting for a host word, chain frozen (prog_mode low)
// SHIFT  | one bit per cycle on ser_data with prog_mode high
// DONE   | done pulse, counters hold their final values
module cgra_prog_ctrl #(
    parameter int NUM_TILES  = 4,
    parameter int MEM_CYCLES = 4096,
    parameter int WORD_W     = 32,
    localparam int WIN   = MEM_CYCLES + 1,
    localparam int TOTAL = NUM_TILES * WIN,
    localparam int CW    = $clog2(TOTAL + 1),
    localparam int TW    = $clog2(NUM_TILES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_data,
    output logic              prog_mode,
    output logic              chain_rst,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CW-1:0]     bit_cnt,
    output logic [TW-1:0]     tile_idx
);

    localparam int BLW = $clog2(WORD_W + 1);
    localparam int WCW = $clog2(WIN + 1);

    localparam logic [CW-1:0]  LAST_BIT  = CW'(TOTAL - 1);
    localparam logic [WCW-1:0] WIN_LAST  = WCW'(WIN - 1);
    localparam logic [BLW-1:0] WORD_BITS = BLW'(WORD_W);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [BLW-1:0]    bits_left;
    logic [WCW-1:0]    win_cnt;
    logic              last_bit;
    logic              word_end;
    logic              accept;
    logic              active;

    // bits_left counts the bit currently on ser_data, so 1 means the wire
    // carries the last bit of the current word.
    assign last_bit = (bit_cnt == LAST_BIT);
    assign word_end = (bits_left == BLW'(1));
    assign active   = (state == S_CLR) || (state == S_FETCH) || (state == S_SHIFT);

    // Abort wins over a concurrent handshake, so the word is left with the host.
    assign in_ready = !abort &&
                      ((state == S_FETCH) ||
                       ((state == S_SHIFT) && word_end && !last_bit));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLR;
            S_CLR:   state_nxt = abort ? S_IDLE : S_FETCH;
            S_FETCH: begin
                if (abort)       state_nxt = S_IDLE;
                else if (accept) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (abort)         state_nxt = S_IDLE;
                else if (last_bit) state_nxt = S_DONE;
                else if (word_end) state_nxt = accept ? S_SHIFT : S_FETCH;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Every output is a flop loaded from the next-state decode, so the chain
    // sees prog_mode and ser_data change together on the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            prog_mode <= 1'b0;
            chain_rst <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            ser_data  <= 1'b0;
            shreg     <= '0;
            bits_left <= '0;
            win_cnt   <= '0;
            bit_cnt   <= '0;
            tile_idx  <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != S_IDLE);
            prog_mode <= (state_nxt == S_SHIFT);
            chain_rst <= (state_nxt == S_CLR);
            done      <= (state_nxt == S_DONE);
            aborted   <= abort && active;

            // shreg holds the bits still to come; bit 0 of a new word goes
            // straight to ser_data so back-to-back words have no bubble.
            if (accept) begin
                ser_data  <= in_data[0];
                shreg     <= in_data >> 1;
                bits_left <= WORD_BITS;
            end else if (state_nxt == S_SHIFT) begin
                ser_data  <= shreg[0];
                shreg     <= shreg >> 1;
                bits_left <= bits_left - BLW'(1);
            end else begin
                ser_data  <= 1'b0;
            end

            // The bit on the wire in SHIFT has been captured by the tiles,
            // including on an abort cycle, so it is always counted.
            if (state == S_CLR) begin
                bit_cnt  <= '0;
                win_cnt  <= '0;
                tile_idx <= '0;
            end else if (state == S_SHIFT) begin
                bit_cnt <= bit_cnt + CW'(1);
                if (win_cnt == WIN_LAST) begin
                    win_cnt  <= '0;
                    tile_idx <= tile_idx + TW'(1);
                end else begin
                    win_cnt  <= win_cnt + WCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cgra_prog_ctrl.sv
// tb_cgra_prog_ctrl
//   Bench for cgra_prog_ctrl. Two instances share one stimulus set: one with
//   4-bit words, one with 5-bit words (both with 2 tiles of 8 bits, so 16
//   bits per pass). sel picks which instance is driven and observed.
//   The reference model works on bit indices: bit i of a pass comes from
//   word i/W, position i%W, and lands in tile i/8.
module tb_cgra_prog_ctrl;

    localparam int NT    = 2;
    localparam int MC    = 7;
    localparam int WIN   = MC + 1;
    localparam int TOTAL = NT * WIN;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic [4:0] in_data;
    logic       sel;

    logic       a_ready, a_ser, a_prog, a_crst, a_busy, a_done, a_aborted;
    logic [4:0] a_bit_cnt;
    logic [1:0] a_tile;
    logic       b_ready, b_ser, b_prog, b_crst, b_busy, b_done, b_aborted;
    logic [4:0] b_bit_cnt;
    logic [1:0] b_tile;

    logic       m_ready, m_ser, m_prog, m_crst, m_busy, m_done, m_aborted;
    logic [4:0] m_bit_cnt;
    logic [1:0] m_tile;

    always #5 clk = ~clk;

    cgra_prog_ctrl #(.NUM_TILES(NT), .MEM_CYCLES(MC), .WORD_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
        .in_data(in_data[3:0]), .in_valid(in_valid & ~sel), .in_ready(a_ready),
        .ser_data(a_ser), .prog_mode(a_prog), .chain_rst(a_crst), .busy(a_busy),
        .done(a_done), .aborted(a_aborted), .bit_cnt(a_bit_cnt), .tile_idx(a_tile)
    );

    cgra_prog_ctrl #(.NUM_TILES(NT), .MEM_CYCLES(MC), .WORD_W(5)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
        .in_data(in_data), .in_valid(in_valid & sel), .in_ready(b_ready),
        .ser_data(b_ser), .prog_mode(b_prog), .chain_rst(b_crst), .busy(b_busy),
        .done(b_done), .aborted(b_aborted), .bit_cnt(b_bit_cnt), .tile_idx(b_tile)
    );

    assign m_ready   = sel ? b_ready   : a_ready;
    assign m_ser     = sel ? b_ser     : a_ser;
    assign m_prog    = sel ? b_prog    : a_prog;
    assign m_crst    = sel ? b_crst    : a_crst;
    assign m_busy    = sel ? b_busy    : a_busy;
    assign m_done    = sel ? b_done    : a_done;
    assign m_aborted = sel ? b_aborted : a_aborted;
    assign m_bit_cnt = sel ? b_bit_cnt : a_bit_cnt;
    assign m_tile    = sel ? b_tile    : a_tile;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // pass bookkeeping shared by the driver and the monitor
    logic [4:0]  words [8];
    int          ww;
    bit          mon_en;
    int          bits_seen, hs_cnt, done_cnt, crst_cnt, abrt_cnt;
    int          gap, fv, max_gap;
    bit          pend, pend_clr, pass_end, prev_prog;
    logic [15:0] cap;

    // Monitor: samples on the falling edge, inputs are stable there.
    initial begin : monitor
        logic [4:0] w;
        bit         boundary;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (m_aborted) begin
                    abrt_cnt++;
                    chk("abort_prog", m_prog, 0);
                    chk("abort_busy", m_busy, 0);
                    pend     = 0;
                    pass_end = 1;
                end
                if (m_prog) begin
                    if (pend) begin
                        // FETCH gap ends on the first cycle in_valid is seen
                        chk("fetch_gap", gap, fv);
                        if (!pend_clr && gap > max_gap) max_gap = gap;
                        pend = 0;
                    end
                    if (bits_seen >= TOTAL) begin
                        chk("extra_bit", bits_seen, TOTAL - 1);
                    end else begin
                        w = words[bits_seen / ww];
                        chk("ser_data", m_ser, w[bits_seen % ww]);
                        chk("bit_cnt", m_bit_cnt, bits_seen);
                        chk("tile_idx", m_tile, bits_seen / WIN);
                        cap[bits_seen] = m_ser;
                        boundary = ((bits_seen % ww) == ww - 1) && (bits_seen != TOTAL - 1);
                        chk("rdy_shift", m_ready, boundary && !abort);
                        if (boundary && !abort) begin
                            pend     = 1;
                            pend_clr = 0;
                            gap      = 0;
                            fv       = in_valid ? 0 : -1;
                        end
                    end
                    bits_seen++;
                end else if (pend) begin
                    gap++;
                    if (fv < 0 && in_valid) fv = gap;
                    chk("rdy_fetch", m_ready, !abort);
                end
                if (m_crst) begin
                    crst_cnt++;
                    chk("clr_busy", m_busy, 1);
                    pend     = 1;
                    pend_clr = 1;
                    gap      = 0;
                    fv       = -1;
                end
                if (m_done) begin
                    done_cnt++;
                    chk("done_bits", bits_seen, TOTAL);
                    chk("done_bit_cnt", m_bit_cnt, TOTAL);
                    chk("done_tile", m_tile, NT);
                    chk("done_after_last", prev_prog, 1);
                    chk("done_prog", m_prog, 0);
                    pass_end = 1;
                end
                if (in_valid && m_ready) hs_cnt++;
                prev_prog = m_prog;
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_prog"}, m_prog, 0);
        chk({tag, "_ser"}, m_ser, 0);
        chk({tag, "_crst"}, m_crst, 0);
        chk({tag, "_busy"}, m_busy, 0);
        chk({tag, "_done"}, m_done, 0);
        chk({tag, "_aborted"}, m_aborted, 0);
        chk({tag, "_bit_cnt"}, m_bit_cnt, 0);
        chk({tag, "_tile"}, m_tile, 0);
        chk({tag, "_ready"}, m_ready, 0);
    endtask

    // One programming pass. pct: in_valid probability; stall_w: word index
    // held back for the whole previous word plus 3 FETCH cycles; abort_at /
    // start_at: bit index at which abort / a stray start is driven.
    task automatic run_pass(input bit use_b, input int pct, input int stall_w,
                            input int abort_at, input int start_at, input bit fixed);
        logic [4:0] fixed_words [4];
        int budget;
        int stall_ctr;
        fixed_words[0] = 5'hA;
        fixed_words[1] = 5'h5;
        fixed_words[2] = 5'hF;
        fixed_words[3] = 5'h0;
        sel = use_b;
        ww  = use_b ? 5 : 4;
        for (int i = 0; i < 8; i++) begin
            words[i] = (fixed && i < 4) ? fixed_words[i] : 5'($urandom);
            if (!use_b) words[i][4] = 1'b0;
        end
        bits_seen = 0; hs_cnt = 0; done_cnt = 0; crst_cnt = 0; abrt_cnt = 0;
        max_gap = 0; pend = 0; pend_clr = 0; pass_end = 0; prev_prog = 0; cap = '0;
        stall_ctr = 0;
        budget    = 0;
        mon_en    = 1;
        @(posedge clk); #1;
        start    = 1;
        in_valid = 0;
        @(posedge clk); #1;
        start = 0;
        while (!pass_end && budget < 300) begin
            in_data = words[hs_cnt & 7];
            if (stall_w >= 0 && hs_cnt == stall_w && stall_ctr < ww + 3) begin
                in_valid = 0;
                stall_ctr++;
            end else begin
                in_valid = ($urandom_range(99) < pct);
            end
            abort = (abort_at >= 0) && m_prog && (m_bit_cnt == abort_at);
            start = (start_at >= 0) && m_prog && (m_bit_cnt == start_at);
            @(posedge clk); #1;
            budget++;
        end
        chk("pass_end", pass_end, 1);
        abort = 0;
        start = 0;
        repeat (2) @(posedge clk);
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        if (abort_at >= 0) begin
            chk("abort_pulses", abrt_cnt, 1);
            chk("abort_no_done", done_cnt, 0);
            chk("abort_bits", bits_seen, abort_at + 1);
        end else begin
            chk("done_pulses", done_cnt, 1);
            chk("words_taken", hs_cnt, (TOTAL + ww - 1) / ww);
            chk("bits_shifted", bits_seen, TOTAL);
        end
        chk("chain_rst_pulses", crst_cnt, 1);
        chk("idle_busy", m_busy, 0);
        mon_en = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int cnt;
        rst = 1; start = 0; abort = 0; in_valid = 0; in_data = '0; sel = 0; mon_en = 0;
        #12;
        check_idle("reset");
        sel = 1;
        check_idle("reset_b");
        sel = 0;
        #5 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("post_reset");

        // 0xA,0x5,0xF,0x0 with in_valid held high: no bubbles
        run_pass(0, 100, -1, -1, -1, 1);
        chk("seq_nostall", cap, 16'h0F5A);
        chk("gap_nostall", max_gap, 0);

        // 3 stalled FETCH cycles before word 3: gap of 3+1, same bit stream
        run_pass(0, 100, 2, -1, -1, 1);
        chk("seq_stall", cap, 16'h0F5A);
        chk("gap_stall", max_gap, 4);

        // 5-bit words: 4 words, last word only partly shifted
        run_pass(1, 100, -1, -1, -1, 0);

        // abort at bit 6, then a clean pass that must restart from bit 0
        run_pass(0, 100, -1, 6, -1, 0);
        run_pass(0, 100, -1, -1, -1, 0);

        // stray start in SHIFT
        run_pass(0, 100, -1, -1, 3, 0);

        // asynchronous reset in the middle of SHIFT
        sel = 0;
        @(posedge clk); #1;
        start = 1; in_valid = 1; in_data = 5'h6;
        @(posedge clk); #1;
        start = 0;
        cnt = 0;
        while (!(m_prog && m_bit_cnt == 5) && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("rst_reach_bit5", m_bit_cnt, 5);
        #2 rst = 1;
        #1;
        check_idle("rst_mid");
        #2 rst = 0;
        @(posedge clk); #1;
        chk("rst_idle_busy", m_busy, 0);
        chk("rst_idle_prog", m_prog, 0);
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stays_idle", m_busy, 0);

        // randomized passes on both word widths, some with aborts
        for (int k = 0; k < 8; k++) begin
            run_pass(1'($urandom_range(1)), $urandom_range(40, 100), -1,
                     ($urandom_range(3) == 0) ? int'($urandom_range(TOTAL - 1)) : -1,
                     -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
